// File: rtl/video_pkg.sv
// Shared video definitions: line-attribute FSM encoding, defaults and tile map geometry.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lineattr_state_e;

  localparam int NUM_TILES_DEF = 41;
  localparam int PRIO_BIT_DEF  = 13;

  localparam int MAP_COLS = 64;
  localparam int MAP_ROWS = 32;
  localparam int COL_W    = $clog2(MAP_COLS);
  localparam int ROW_W    = $clog2(MAP_ROWS);
  localparam int VADDR_W  = 13;
  localparam int TILE_W   = 7;

  // Map word address of (row, col), wrapping modulo the VRAM word space.
  function automatic logic [VADDR_W-1:0] map_addr(input logic [VADDR_W-1:0] base,
                                                  input logic [ROW_W-1:0]   row,
                                                  input logic [COL_W-1:0]   col);
    return base + {{(VADDR_W-ROW_W-COL_W){1'b0}}, row, col};
  endfunction

endpackage

// File: rtl/tile_lineattr_fetch.sv
// VRAM map-entry fetcher: req/ack handshake, map address generation and entry register(s).
// Build option TILE_LINEATTR_PREFETCH_EN adds a next-entry slot filled during the write burst.
module tile_lineattr_fetch
  import video_pkg::*;
#(
  parameter logic [VADDR_W-1:0] MAP_BASE = 13'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [ROW_W-1:0]    i_row,
  input  logic [COL_W-1:0]    i_col0,
  input  logic                i_issue,
  input  logic [TILE_W-1:0]   i_tile,
  input  logic                i_to_cur,
  input  logic                i_advance,
  output logic                o_ack,
  output logic                o_next_ok,
  output logic [15:0]         o_entry,
  output logic                o_vram_req,
  output logic [VADDR_W-1:0]  o_vram_addr,
  input  logic                i_vram_ack,
  input  logic [15:0]         i_vram_rddata
);

  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col0;
  logic               r_req;
  logic [VADDR_W-1:0] r_addr;
  logic [15:0]        r_cur;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col0;
  logic [COL_W-1:0]   w_col;

  // The first fetch is issued in the start cycle, before the latched copies are valid.
  assign w_row  = i_load ? i_row  : r_row;
  assign w_col0 = i_load ? i_col0 : r_col0;
  assign w_col  = w_col0 + i_tile[COL_W-1:0];

  assign o_ack       = r_req & i_vram_ack;
  assign o_vram_req  = r_req;
  assign o_vram_addr = r_req ? r_addr : '0;
  assign o_entry     = r_cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col0 <= '0;
      r_req  <= 1'b0;
      r_addr <= '0;
    end else begin
      if (i_load) begin
        r_row  <= i_row;
        r_col0 <= i_col0;
      end
      if (i_issue) begin
        r_req  <= 1'b1;
        r_addr <= map_addr(MAP_BASE, w_row, w_col);
      end else if (o_ack) begin
        r_req  <= 1'b0;
      end
    end
  end

`ifdef TILE_LINEATTR_PREFETCH_EN
  logic [15:0] r_next;
  logic        r_next_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_next     <= '0;
      r_next_vld <= 1'b0;
    end else if (i_advance) begin
      r_cur      <= r_next_vld ? r_next : i_vram_rddata;
      r_next_vld <= 1'b0;
    end else if (o_ack) begin
      if (i_to_cur) begin
        r_cur      <= i_vram_rddata;
      end else begin
        r_next     <= i_vram_rddata;
        r_next_vld <= 1'b1;
      end
    end
  end

  assign o_next_ok = r_next_vld | o_ack;
`else
  logic w_unused_pf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur <= '0;
    end else if (o_ack) begin
      r_cur <= i_vram_rddata;
    end
  end

  assign o_next_ok   = o_ack;
  assign w_unused_pf = i_to_cur ^ i_advance;
`endif

endmodule

// File: rtl/tile_lineattr_gen.sv
// Per-scanline line-attribute buffer filler: walks the tile map row and writes 8 priority bits per tile.
// Build option TILE_LINEATTR_PREFETCH_EN overlaps the next tile fetch with the current write burst.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_FETCH | map entry request outstanding for current tile
//   ST_WRITE | 8-cycle write burst for current tile
//   ST_DONE  | one-cycle done pulse
module tile_lineattr_gen
  import video_pkg::*;
#(
  parameter int                 NUM_TILES = NUM_TILES_DEF,
  parameter logic [VADDR_W-1:0] MAP_BASE  = 13'h0,
  parameter int                 PRIO_BIT  = PRIO_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                layer_en,
  input  logic [7:0]          line,
  input  logic [8:0]          scrx,
  output logic                vram_req,
  output logic [VADDR_W-1:0]  vram_addr,
  input  logic                vram_ack,
  input  logic [15:0]         vram_rddata,
  output logic [8:0]          wr_idx,
  output logic                wr_data,
  output logic                wr_en,
  output logic                busy,
  output logic                done
);

  localparam int                POS_W     = TILE_W + 3;
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  lineattr_state_e   r_state, w_state_nxt;
  logic [TILE_W-1:0] r_tile, w_tile_nxt;
  logic [2:0]        r_k, w_k_nxt;
  logic              r_layer;
  logic [2:0]        r_fine;

  logic              w_load, w_issue, w_to_cur, w_advance;
  logic [TILE_W-1:0] w_fetch_tile;
  logic              w_ack, w_next_ok;
  logic [15:0]       w_entry;
  logic              w_last_tile, w_burst_end, w_writing;
  logic [POS_W-1:0]  w_pos, w_idx_full;
  logic              w_unused;

  tile_lineattr_fetch #(.MAP_BASE(MAP_BASE)) u_fetch (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_row         (line[7:3]),
    .i_col0        (scrx[8:3]),
    .i_issue       (w_issue),
    .i_tile        (w_fetch_tile),
    .i_to_cur      (w_to_cur),
    .i_advance     (w_advance),
    .o_ack         (w_ack),
    .o_next_ok     (w_next_ok),
    .o_entry       (w_entry),
    .o_vram_req    (vram_req),
    .o_vram_addr   (vram_addr),
    .i_vram_ack    (vram_ack),
    .i_vram_rddata (vram_rddata)
  );

  assign w_last_tile = (r_tile == LAST_TILE);
  assign w_burst_end = (r_k == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tile  <= '0;
      r_k     <= '0;
      r_layer <= 1'b0;
      r_fine  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tile  <= w_tile_nxt;
      r_k     <= w_k_nxt;
      if (w_load) begin
        r_layer <= layer_en;
        r_fine  <= scrx[2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tile_nxt   = r_tile;
    w_k_nxt      = r_k;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    w_fetch_tile = r_tile;
    w_to_cur     = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_tile_nxt   = '0;
          w_k_nxt      = '0;
          w_fetch_tile = '0;
          if (layer_en) begin
            w_issue     = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_FETCH: begin
        w_to_cur = 1'b1;
        if (w_ack) begin
          w_state_nxt = ST_WRITE;
          w_k_nxt     = '0;
`ifdef TILE_LINEATTR_PREFETCH_EN
          if (!w_last_tile) begin
            w_issue      = 1'b1;
            w_fetch_tile = r_tile + TILE_W'(1);
          end
`endif
        end
      end
      ST_WRITE: begin
        w_k_nxt = r_k + 3'd1;
        if (w_burst_end) begin
          if (w_last_tile) begin
            w_state_nxt = ST_DONE;
          end else if (!r_layer) begin
            w_tile_nxt = r_tile + TILE_W'(1);
`ifdef TILE_LINEATTR_PREFETCH_EN
          end else if (w_next_ok) begin
            w_advance  = 1'b1;
            w_tile_nxt = r_tile + TILE_W'(1);
            if (r_tile < LAST_TILE - TILE_W'(1)) begin
              w_issue      = 1'b1;
              w_fetch_tile = r_tile + TILE_W'(2);
            end
          end else begin
            // Next entry still in flight: park in FETCH; its ack lands in the current slot.
            w_tile_nxt  = r_tile + TILE_W'(1);
            w_state_nxt = ST_FETCH;
          end
`else
          end else begin
            w_tile_nxt   = r_tile + TILE_W'(1);
            w_issue      = 1'b1;
            w_fetch_tile = r_tile + TILE_W'(1);
            w_state_nxt  = ST_FETCH;
          end
`endif
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pixel p = tile*8 + k; positions left of the fine scroll would wrap below 0 and are dropped.
  assign w_writing  = (r_state == ST_WRITE);
  assign w_pos      = {r_tile, r_k};
  assign w_idx_full = w_pos - {{TILE_W{1'b0}}, r_fine};

  assign wr_en   = w_writing && (w_pos >= {{TILE_W{1'b0}}, r_fine});
  assign wr_idx  = w_writing ? w_idx_full[8:0] : '0;
  assign wr_data = w_writing & r_layer & w_entry[PRIO_BIT];
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);

  assign w_unused = ^{line[2:0], w_idx_full[POS_W-1:9], w_entry, w_next_ok};

endmodule

// File: tb/tb_tile_lineattr_gen.sv
// Self-checking bench for tile_lineattr_gen; expectations adapt to TILE_LINEATTR_PREFETCH_EN.
module tb_tile_lineattr_gen;

  localparam int          NT   = 41;
  localparam logic [12:0] BASE = 13'h1FC0;
  localparam int          PB   = 13;
`ifdef TILE_LINEATTR_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        layer_en = 1'b0;
  logic [7:0]  line = '0;
  logic [8:0]  scrx = '0;
  logic        vram_req;
  logic [12:0] vram_addr;
  logic        vram_ack = 1'b0;
  logic [15:0] vram_rddata = '0;
  logic [8:0]  wr_idx;
  logic        wr_data, wr_en, busy, done;

  tile_lineattr_gen #(.NUM_TILES(NT), .MAP_BASE(BASE), .PRIO_BIT(PB)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .layer_en    (layer_en),
    .line        (line),
    .scrx        (scrx),
    .vram_req    (vram_req),
    .vram_addr   (vram_addr),
    .vram_ack    (vram_ack),
    .vram_rddata (vram_rddata),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] idx;
    logic       dat;
  } wr_t;

  typedef struct {
    logic       le;
    logic [7:0] ln;
    logic [8:0] sx;
    int         d;
    int         nwr;
  } vec_t;

  wr_t         exp_wr[$];
  logic [12:0] exp_addr[$];
  wr_t         mon_e;
  vec_t        vecs[7];

  int n_cmp = 0, n_bad = 0;
  int ack_delay = 0, wait_cnt = 0;
  int n_wr = 0, n_done = 0, n_req = 0;
  logic        prev_hold = 1'b0;
  logic [12:0] prev_addr = '0;

  // VRAM map content: priority bit varies with column and row.
  function automatic logic [15:0] mem_entry(input logic [12:0] a);
    return {2'b00, a[0] ^ a[6], a};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic build_model(input logic le, input logic [7:0] ln, input logic [8:0] sx);
    exp_wr.delete();
    exp_addr.delete();
    for (int i = 0; i < NT; i++) begin
      logic [5:0]  col;
      logic [12:0] a;
      logic [15:0] ent;
      logic        pr;
      col = 6'((sx >> 3) + i);
      a   = 13'(BASE + (ln >> 3) * 64 + col);
      ent = mem_entry(a);
      pr  = le ? ent[PB] : 1'b0;
      if (le) exp_addr.push_back(a);
      for (int k = 0; k < 8; k++) begin
        int p;
        p = i * 8 + k;
        if (p >= int'(sx[2:0])) exp_wr.push_back('{idx: 9'(p - int'(sx[2:0])), dat: pr});
      end
    end
  endtask

  function automatic int exp_cycles(input logic le, input int d);
    if (!le) return NT * 8;
    if (PF) return 1 + d + NT * 8;
    return NT * (9 + d);
  endfunction

  // Monitor and VRAM responder, working on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      if (exp_wr.size() == 0) begin
        check("write_unexpected", int'(wr_idx), -1);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_idx", int'(wr_idx), int'(mon_e.idx));
        check("wr_data", int'(wr_data), int'(mon_e.dat));
      end
    end
    if (done) n_done++;
    if (prev_hold) begin
      check("req_held", int'(vram_req), 1);
      check("addr_held", int'(vram_addr), int'(prev_addr));
    end
    if (vram_req) begin
      n_req++;
      if (wait_cnt >= ack_delay) begin
        vram_ack    = 1'b1;
        vram_rddata = mem_entry(vram_addr);
        wait_cnt    = 0;
        prev_hold   = 1'b0;
        if (exp_addr.size() == 0) check("req_unexpected", int'(vram_addr), -1);
        else check("fetch_addr", int'(vram_addr), int'(exp_addr.pop_front()));
      end else begin
        vram_ack    = 1'b0;
        vram_rddata = 16'($urandom);
        wait_cnt++;
        prev_hold   = 1'b1;
        prev_addr   = vram_addr;
      end
    end else begin
      vram_ack    = 1'b0;
      vram_rddata = 16'($urandom);
      wait_cnt    = 0;
      prev_hold   = 1'b0;
    end
  end

  task automatic kick(input logic le, input logic [7:0] ln, input logic [8:0] sx);
    @(negedge clk);
    start = 1'b1; layer_en = le; line = ln; scrx = sx;
    @(negedge clk);
    start = 1'b0; layer_en = ~le; line = ~ln; scrx = ~sx;
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic finish_fill(input string tag, input logic le, input int nwr);
    repeat (3) @(negedge clk);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_writes"}, n_wr, nwr);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_wr_left"}, exp_wr.size(), 0);
    check({tag, "_addr_left"}, exp_addr.size(), 0);
    if (!le) check({tag, "_req_cycles"}, n_req, 0);
  endtask

  task automatic run_fill(input string tag, input vec_t v);
    int cyc;
    bit got;
    build_model(v.le, v.ln, v.sx);
    ack_delay = v.d;
    n_wr = 0; n_done = 0; n_req = 0;
    kick(v.le, v.ln, v.sx);
    wait_done(cyc, got);
    check({tag, "_done_seen"}, int'(got), 1);
    check({tag, "_cycles"}, cyc, exp_cycles(v.le, v.d));
    finish_fill(tag, v.le, v.nwr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  got;
    vecs[0] = '{1'b1, 8'h00, 9'h000, 0, 328};
    vecs[1] = '{1'b1, 8'h00, 9'h10B, 0, 325};
    vecs[2] = '{1'b1, 8'h00, 9'h000, 3, 328};
    vecs[3] = '{1'b0, 8'h00, 9'h005, 0, 323};
    vecs[4] = '{1'b1, 8'hFF, 9'h000, 0, 328};
    vecs[5] = '{1'b1, 8'hFF, 9'h1C7, 3, 321};
    vecs[6] = '{1'b1, 8'h5D, 9'h1F4, 1, 324};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_req", int'(vram_req), 0);
    rst_n = 1'b1;

    foreach (vecs[n]) run_fill($sformatf("vec%0d", n), vecs[n]);

    // start while busy and in the DONE cycle are both ignored
    build_model(1'b1, 8'h20, 9'h013);
    ack_delay = 0; n_wr = 0; n_done = 0; n_req = 0;
    kick(1'b1, 8'h20, 9'h013);
    repeat (50) @(negedge clk);
    start = 1'b1; layer_en = 1'b0; scrx = 9'h000;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, got);
    check("restart_done_seen", int'(got), 1);
    start = 1'b1; layer_en = 1'b1; scrx = 9'h000;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", int'(busy), 0);
    finish_fill("restart", 1'b1, 325);

    // reset mid-fill aborts without a done pulse
    build_model(1'b1, 8'h00, 9'h000);
    ack_delay = 0; n_wr = 0; n_done = 0; n_req = 0;
    kick(1'b1, 8'h00, 9'h000);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_wr_idx", int'(wr_idx), 0);
    check("abort_wr_data", int'(wr_data), 0);
    check("abort_req", int'(vram_req), 0);
    check("abort_addr", int'(vram_addr), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check("abort_idle", int'(busy), 0);
    run_fill("post_reset", vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
